// File: rtl/ctrl_flow_seq_if.sv
// Decode/fetch-side bundle for the control-transfer sequencer.
// The slave modport is the sequencer; the master modport is decode/memory.
interface ctrl_flow_seq_if #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 32,
    parameter int FLAG_W  = 3,
    parameter int INSTR_W = 16
);
    logic               call;
    logic               ret;
    logic               intr;
    logic               rti;
    logic [PC_W-1:0]    target;
    logic [PC_W-1:0]    ret_pc;
    logic [FLAG_W-1:0]  flags_in;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_rvalid;

    logic [INSTR_W-1:0] uop_out;
    logic               uop_valid;
    logic [DATA_W-1:0]  push_data;
    logic               stall;
    logic [PC_W-1:0]    pc_out;
    logic               change_pc;
    logic [FLAG_W-1:0]  flags_out;
    logic               restore_flags;
    logic               busy;

    modport slave (
        input  call, ret, intr, rti, target, ret_pc, flags_in, mem_rdata, mem_rvalid,
        output uop_out, uop_valid, push_data, stall, pc_out, change_pc,
               flags_out, restore_flags, busy
    );

    modport master (
        output call, ret, intr, rti, target, ret_pc, flags_in, mem_rdata, mem_rvalid,
        input  uop_out, uop_valid, push_data, stall, pc_out, change_pc,
               flags_out, restore_flags, busy
    );
endinterface

// File: rtl/ctrl_flow_seq.sv
// CALL/RET/INT/RTI sequencer: injects stack push/pop micro-ops, drains the
// pipeline, then redirects the PC with a one-cycle change pulse.
module ctrl_flow_seq #(
    parameter int                 DATA_W       = 16,
    parameter int                 PC_W         = 32,
    parameter int                 FLAG_W       = 3,
    parameter int                 INSTR_W      = 16,
    parameter int                 STALL_CYCLES = 2,
    parameter logic [PC_W-1:0]    INT_VECTOR   = 32'h0000_0020,
    parameter logic [INSTR_W-1:0] PUSH_OP      = 16'h6008,
    parameter logic [INSTR_W-1:0] POP_OP       = 16'h7008
) (
    input  logic             clk,
    input  logic             reset,
    ctrl_flow_seq_if.slave   bus
);
    localparam int NW = PC_W / DATA_W;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int DW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_PUSH, S_PUSHF, S_POP, S_POP_WAIT, S_POPF, S_POPF_WAIT, S_DRAIN, S_JUMP
    } state_t;

    state_t             r_state;
    logic               r_pend;
    logic               r_is_int;
    logic               r_is_rti;
    logic [IW-1:0]      r_idx;
    logic [DW-1:0]      r_drain;
    logic [PC_W-1:0]    r_ret;
    logic [PC_W-1:0]    r_tgt;
    logic [FLAG_W-1:0]  r_flags;

    logic [INSTR_W-1:0] r_uop;
    logic               r_uop_valid;
    logic [DATA_W-1:0]  r_push_data;
    logic [PC_W-1:0]    r_pc;
    logic               r_change;
    logic [FLAG_W-1:0]  r_flags_out;
    logic               r_restore;

    logic               w_idle;
    logic               w_acc_int;
    logic               w_acc_call;
    logic               w_acc_ret;
    logic               w_acc_rti;
    logic               w_accept;
    logic               w_fin;
    logic               w_to_jump;
    logic [PC_W-1:0]    w_tgt_nxt;

    assign w_idle     = (r_state == S_IDLE);
    assign w_acc_int  = w_idle & (r_pend | bus.intr);
    assign w_acc_call = w_idle & ~w_acc_int & bus.call;
    assign w_acc_ret  = w_idle & ~w_acc_int & ~bus.call & bus.ret;
    assign w_acc_rti  = w_idle & ~w_acc_int & ~bus.call & ~bus.ret & bus.rti;
    assign w_accept   = w_acc_int | w_acc_call | w_acc_ret | w_acc_rti;

    // Last stack op of a sequence: what follows is DRAIN, or JUMP directly
    // when no drain is configured.
    assign w_fin = ((r_state == S_PUSH) && (r_idx == IW'(NW-1)) && !r_is_int)
                 || (r_state == S_PUSHF)
                 || ((r_state == S_POP_WAIT) && bus.mem_rvalid && (r_idx == '0));
    assign w_to_jump = (w_fin && (STALL_CYCLES == 0))
                     || ((r_state == S_DRAIN) && (r_drain == '0));

    // Popped word merged in the same cycle so a zero-drain RET jumps to the
    // fully assembled PC.
    always_comb begin
        w_tgt_nxt = r_tgt;
        if ((r_state == S_POP_WAIT) && bus.mem_rvalid)
            w_tgt_nxt[int'(r_idx)*DATA_W +: DATA_W] = bus.mem_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_pend      <= 1'b0;
            r_is_int    <= 1'b0;
            r_is_rti    <= 1'b0;
            r_idx       <= '0;
            r_drain     <= '0;
            r_ret       <= '0;
            r_tgt       <= '0;
            r_flags     <= '0;
            r_uop       <= '0;
            r_uop_valid <= 1'b0;
            r_push_data <= '0;
            r_pc        <= '0;
            r_change    <= 1'b0;
            r_flags_out <= '0;
            r_restore   <= 1'b0;
        end else begin
            r_uop       <= '0;
            r_uop_valid <= 1'b0;
            r_push_data <= '0;
            r_change    <= 1'b0;
            r_restore   <= 1'b0;
            r_tgt       <= w_tgt_nxt;

            if (w_acc_int)
                r_pend <= 1'b0;
            else if (!w_idle && bus.intr)
                r_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_acc_int || w_acc_call) begin
                        r_state     <= S_PUSH;
                        r_idx       <= '0;
                        r_is_int    <= w_acc_int;
                        r_is_rti    <= 1'b0;
                        r_ret       <= bus.ret_pc;
                        r_tgt       <= w_acc_int ? INT_VECTOR : bus.target;
                        r_uop       <= PUSH_OP;
                        r_uop_valid <= 1'b1;
                        r_push_data <= bus.ret_pc[DATA_W-1:0];
                        if (w_acc_int)
                            r_flags <= bus.flags_in;
                    end else if (w_acc_ret) begin
                        r_state     <= S_POP;
                        r_idx       <= IW'(NW-1);
                        r_is_int    <= 1'b0;
                        r_is_rti    <= 1'b0;
                        r_uop       <= POP_OP + INSTR_W'(NW-1);
                        r_uop_valid <= 1'b1;
                    end else if (w_acc_rti) begin
                        r_state     <= S_POPF;
                        r_is_int    <= 1'b0;
                        r_is_rti    <= 1'b1;
                        r_uop       <= POP_OP + INSTR_W'(NW);
                        r_uop_valid <= 1'b1;
                    end
                end
                S_PUSH: begin
                    if (r_idx != IW'(NW-1)) begin
                        r_idx       <= r_idx + 1'b1;
                        r_uop       <= PUSH_OP + INSTR_W'(int'(r_idx) + 1);
                        r_uop_valid <= 1'b1;
                        r_push_data <= r_ret[(int'(r_idx)+1)*DATA_W +: DATA_W];
                    end else if (r_is_int) begin
                        r_state     <= S_PUSHF;
                        r_uop       <= PUSH_OP + INSTR_W'(NW);
                        r_uop_valid <= 1'b1;
                        r_push_data <= DATA_W'(r_flags);
                    end
                end
                S_PUSHF: ;
                S_POP:   r_state <= S_POP_WAIT;
                S_POP_WAIT: begin
                    if (bus.mem_rvalid && (r_idx != '0)) begin
                        r_state     <= S_POP;
                        r_idx       <= r_idx - 1'b1;
                        r_uop       <= POP_OP + INSTR_W'(int'(r_idx) - 1);
                        r_uop_valid <= 1'b1;
                    end
                end
                S_POPF:  r_state <= S_POPF_WAIT;
                S_POPF_WAIT: begin
                    if (bus.mem_rvalid) begin
                        r_state     <= S_POP;
                        r_flags     <= bus.mem_rdata[FLAG_W-1:0];
                        r_idx       <= IW'(NW-1);
                        r_uop       <= POP_OP + INSTR_W'(NW-1);
                        r_uop_valid <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain != '0)
                        r_drain <= r_drain - 1'b1;
                end
                S_JUMP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Sequence tail overrides the per-state next state above.
            if (w_to_jump) begin
                r_state  <= S_JUMP;
                r_pc     <= w_tgt_nxt;
                r_change <= 1'b1;
                if (r_is_rti) begin
                    r_flags_out <= r_flags;
                    r_restore   <= 1'b1;
                end
            end else if (w_fin) begin
                r_state <= S_DRAIN;
                r_drain <= DW'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);
            end
        end
    end

    assign bus.stall         = ~w_idle | w_accept;
    assign bus.busy          = ~w_idle;
    assign bus.uop_out       = r_uop;
    assign bus.uop_valid     = r_uop_valid;
    assign bus.push_data     = r_push_data;
    assign bus.pc_out        = r_pc;
    assign bus.change_pc     = r_change;
    assign bus.flags_out     = r_flags_out;
    assign bus.restore_flags = r_restore;
endmodule

// File: tb/tb_ctrl_flow_seq.sv
// Randomized bench for ctrl_flow_seq: each transaction is expanded into an
// expected per-cycle trace from the sequencing rules and compared cycle by cycle.
module tb_ctrl_flow_seq;
    localparam int DATA_W = 16, PC_W = 32, FLAG_W = 3, INSTR_W = 16, STALL_CYCLES = 2;
    localparam int NW = PC_W / DATA_W;
    localparam logic [PC_W-1:0]    INT_VECTOR = 32'h0000_0020;
    localparam logic [INSTR_W-1:0] PUSH_OP = 16'h6008;
    localparam logic [INSTR_W-1:0] POP_OP  = 16'h7008;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ctrl_flow_seq_if #(.DATA_W(DATA_W), .PC_W(PC_W), .FLAG_W(FLAG_W), .INSTR_W(INSTR_W)) bus ();

    ctrl_flow_seq #(
        .DATA_W(DATA_W), .PC_W(PC_W), .FLAG_W(FLAG_W), .INSTR_W(INSTR_W),
        .STALL_CYCLES(STALL_CYCLES), .INT_VECTOR(INT_VECTOR),
        .PUSH_OP(PUSH_OP), .POP_OP(POP_OP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        bit                 call, ret, intr, rti, rv, drv_in;
        logic [DATA_W-1:0]  rdata;
        logic [PC_W-1:0]    tgt, rpc;
        logic [FLAG_W-1:0]  fl;
        logic [INSTR_W-1:0] uop;
        bit                 uv, stall, busy, chg, rst;
        logic [DATA_W-1:0]  pd;
        logic [PC_W-1:0]    pc;
        logic [FLAG_W-1:0]  fo;
    } cyc_t;

    cyc_t              q[$];
    logic [PC_W-1:0]   m_pc = '0;
    logic [FLAG_W-1:0] m_fl = '0;
    bit                m_pend = 1'b0;
    int                n_tests = 0;
    int                n_fail = 0;
    int                ncyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c = '{default: '0};
        c.rv    = 1'($urandom_range(0, 1));
        c.rdata = DATA_W'($urandom);
        c.pc    = m_pc;
        c.fo    = m_fl;
        return c;
    endfunction

    function automatic cyc_t bcyc(input logic [INSTR_W-1:0] u, input bit v, input logic [DATA_W-1:0] d);
        cyc_t c;
        c = idle_cyc();
        c.uop = u; c.uv = v; c.pd = d; c.stall = 1'b1; c.busy = 1'b1;
        return c;
    endfunction

    // One pop: the op cycle, then dly wait cycles with the word returned on the last.
    function automatic void add_pop(input logic [INSTR_W-1:0] op, input logic [DATA_W-1:0] w, input int dly);
        int d;
        d = (dly > 0) ? dly : int'($urandom_range(1, 4));
        q.push_back(bcyc(op, 1'b1, '0));
        for (int k = 0; k < d; k++) begin
            cyc_t c;
            c = bcyc('0, 1'b0, '0);
            c.rv    = (k == d - 1);
            c.rdata = (k == d - 1) ? w : DATA_W'($urandom);
            q.push_back(c);
        end
    endfunction

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            bus.call = c.call; bus.ret = c.ret; bus.intr = c.intr; bus.rti = c.rti;
            bus.mem_rvalid = c.rv; bus.mem_rdata = c.rdata;
            if (c.drv_in) begin
                bus.target = c.tgt; bus.ret_pc = c.rpc; bus.flags_in = c.fl;
            end else begin
                bus.target = PC_W'($urandom); bus.ret_pc = PC_W'($urandom);
                bus.flags_in = FLAG_W'($urandom);
            end
            @(negedge clk);
            chk($sformatf("uop@%0d", ncyc), 64'({bus.uop_valid, bus.uop_out, bus.push_data}),
                64'({c.uv, c.uop, c.pd}));
            chk($sformatf("stall_busy@%0d", ncyc), 64'({bus.stall, bus.busy}), 64'({c.stall, c.busy}));
            chk($sformatf("pc@%0d", ncyc), 64'({bus.change_pc, bus.pc_out}), 64'({c.chg, c.pc}));
            chk($sformatf("flags@%0d", ncyc), 64'({bus.restore_flags, bus.flags_out}), 64'({c.rst, c.fo}));
            @(posedge clk);
            #1;
            ncyc++;
        end
    endtask

    // kind: 0 INT, 1 CALL, 2 RET, 3 RTI. lower: 0 none, 1 all, 2 random lower-priority strobes.
    task automatic add_txn(input int kind, input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] rpc,
                           input logic [FLAG_W-1:0] fl, input logic [PC_W-1:0] popv,
                           input logic [DATA_W-1:0] fw, input int dly, input int intr_at, input int lower);
        cyc_t c;
        int s;
        bit fp;
        bit rb[3];
        logic [PC_W-1:0] dest;
        logic [FLAG_W-1:0] nfl;
        fp = m_pend; m_pend = 1'b0; nfl = m_fl;
        for (int k = 0; k < 3; k++)
            rb[k] = (lower == 1) ? 1'b1 : (lower == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        c = idle_cyc();
        c.stall = 1'b1; c.drv_in = 1'b1; c.tgt = tgt; c.rpc = rpc; c.fl = fl;
        if (kind == 0) begin
            c.intr = fp ? 1'($urandom_range(0, 1)) : 1'b1;
            c.call = rb[0]; c.ret = rb[1]; c.rti = rb[2];
        end else if (kind == 1) begin
            c.call = 1'b1; c.ret = rb[1]; c.rti = rb[2];
        end else if (kind == 2) begin
            c.ret = 1'b1; c.rti = rb[2];
        end else begin
            c.rti = 1'b1;
        end
        q.push_back(c);
        s = q.size();
        if (kind < 2) begin
            for (int i = 0; i < NW; i++)
                q.push_back(bcyc(PUSH_OP + INSTR_W'(i), 1'b1, rpc[i*DATA_W +: DATA_W]));
            if (kind == 0)
                q.push_back(bcyc(PUSH_OP + INSTR_W'(NW), 1'b1, DATA_W'(fl)));
            dest = (kind == 0) ? INT_VECTOR : tgt;
        end else begin
            if (kind == 3) begin
                add_pop(POP_OP + INSTR_W'(NW), fw, dly);
                nfl = fw[FLAG_W-1:0];
            end
            for (int i = NW - 1; i >= 0; i--)
                add_pop(POP_OP + INSTR_W'(i), popv[i*DATA_W +: DATA_W], dly);
            dest = popv;
        end
        for (int i = 0; i < STALL_CYCLES; i++)
            q.push_back(bcyc('0, 1'b0, '0));
        m_pc = dest;
        m_fl = nfl;
        c = bcyc('0, 1'b0, '0);
        c.chg = 1'b1; c.rst = (kind == 3);
        q.push_back(c);
        if (intr_at >= 0) begin
            int k;
            k = s + (intr_at % (q.size() - s));
            q[k].intr = 1'b1;
            m_pend = 1'b1;
        end
        if (!m_pend)
            repeat ($urandom_range(1, 2)) q.push_back(idle_cyc());
        run_q();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.call = 0; bus.ret = 0; bus.intr = 0; bus.rti = 0;
        bus.target = '0; bus.ret_pc = '0; bus.flags_in = '0;
        bus.mem_rdata = '0; bus.mem_rvalid = 0;
        #2 reset = 1'b0;
        #5;
        chk("reset_uop", 64'({bus.uop_valid, bus.uop_out, bus.push_data}), 64'd0);
        chk("reset_ctl", 64'({bus.stall, bus.busy, bus.change_pc, bus.restore_flags, bus.flags_out}), 64'd0);
        chk("reset_pc", 64'(bus.pc_out), 64'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        add_txn(1, 32'h0000_0100, 32'h0001_2345, 3'b000, '0, '0, 0, -1, 0);
        add_txn(2, '0, '0, 3'b000, 32'h0001_2345, '0, 3, -1, 0);
        add_txn(0, 32'hdead_beef, 32'h0000_0042, 3'b101, '0, '0, 0, -1, 0);
        add_txn(3, '0, '0, 3'b000, 32'h0000_0042, 16'h0005, 0, -1, 0);
        add_txn(1, 32'h0000_0200, 32'h0000_1111, 3'b000, '0, '0, 0, NW, 0);
        add_txn(0, '0, 32'h0000_2222, 3'b011, '0, '0, 0, -1, 0);
        add_txn(1, 32'h0000_0300, 32'h0000_3333, 3'b000, '0, '0, 0, -1, 1);

        for (int n = 0; n < 40; n++) begin
            int kind;
            int ia;
            kind = m_pend ? 0 : int'($urandom_range(0, 3));
            ia = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
            add_txn(kind, PC_W'($urandom), PC_W'($urandom), FLAG_W'($urandom),
                    PC_W'($urandom), DATA_W'($urandom), 0, ia, 2);
        end
        if (m_pend)
            add_txn(0, '0, PC_W'($urandom), FLAG_W'($urandom), '0, '0, 0, -1, 0);

        // Reset while a RET waits for its first pop.
        bus.ret = 1'b1; bus.mem_rvalid = 1'b0;
        @(posedge clk); #1;
        bus.ret = 1'b0; bus.mem_rvalid = 1'b1;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("abort_ctl", 64'({bus.uop_valid, bus.uop_out, bus.push_data, bus.stall, bus.busy,
                              bus.change_pc, bus.restore_flags}), 64'd0);
        chk("abort_pc", 64'({bus.pc_out, bus.flags_out}), 64'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_abort%0d", k), 64'({bus.change_pc, bus.busy, bus.stall, bus.uop_valid, bus.pc_out}),
                64'd0);
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_flow_seq.md
# ctrl_flow_seq

Parametrised control-transfer sequencer sitting between decode and the fetch/PC logic of the five-stage pipeline. It handles CALL, RET, hardware interrupt (INT) and RTI. It injects stack push/pop micro-ops into the pipeline and stalls fetch while doing so. It then redirects the PC with a one-cycle change pulse. PC width, stack word width, flag width, drain length and micro-op encodings are all parameters.

## Interface
- DATA_W, 16, stack word width; PC_W must be a multiple of it
- PC_W, 32, PC width; NW = PC_W/DATA_W words per PC (NW ≥ 1)
- FLAG_W, 3, CCR flag width (FLAG_W ≤ DATA_W)
- INSTR_W, 16, micro-op width
- STALL_CYCLES, 2, NOP drain cycles before the PC change (0 allowed)
- INT_VECTOR, 32'h0000_0020, interrupt target PC
- PUSH_OP, 16'h6008, push of PC word i is PUSH_OP+i; flags push is PUSH_OP+NW
- POP_OP, 16'h7008, pop of PC word i is POP_OP+i; flags pop is POP_OP+NW
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- call, ret, intr, rti  in  1 each  request strobes from decode/interrupt controller
- target  in  PC_W  CALL destination, latched at accept
- ret_pc  in  PC_W  return address to push, latched at CALL/INT accept
- flags_in  in  FLAG_W  current flags, latched at INT accept
- mem_rdata  in  DATA_W  popped word from memory stage
- mem_rvalid  in  1  mem_rdata valid
- uop_out  out  INSTR_W  injected micro-op (0 = NOP)
- uop_valid  out  1  uop_out is a real push/pop
- push_data  out  DATA_W  data word for the current push
- stall  out  1  freeze fetch/decode
- pc_out  out  PC_W  new PC
- change_pc  out  1  one-cycle PC redirect pulse
- flags_out  out  FLAG_W  restored flags
- restore_flags  out  1  one-cycle flags restore pulse (RTI only)
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, PUSH, PUSHF, POP, POP_WAIT, POPF, POPF_WAIT, DRAIN, JUMP.
- Accept happens only in IDLE. Priority: pending/intr > call > ret > rti. Lower-priority strobes arriving in the same cycle are dropped.
- intr asserted while busy sets a pending bit. The pending INT is serviced in the first IDLE cycle after the current sequence; the pending bit clears on accept.
- CALL: PUSH words 0..NW-1, low word first (uop_out = PUSH_OP+i, push_data = ret_pc[i]), then DRAIN, then JUMP to target.
- INT: same as CALL, plus PUSHF after the PC words (uop_out = PUSH_OP+NW, push_data = zero-extended flags). JUMP goes to INT_VECTOR.
- RET: for i = NW-1 down to 0, POP emits POP_OP+i for one cycle, then POP_WAIT holds until mem_rvalid. mem_rdata is stored into PC word i. Then DRAIN, then JUMP to the assembled PC.
- RTI: POPF (POP_OP+NW) then POPF_WAIT, capturing mem_rdata[FLAG_W-1:0]. Then the RET pop sequence. In JUMP, restore_flags=1 with flags_out valid.
- DRAIN: uop_out = 0 and uop_valid = 0 for STALL_CYCLES cycles. With STALL_CYCLES = 0, DRAIN is skipped.
- JUMP: change_pc = 1 for one cycle, then IDLE. pc_out and flags_out hold their values afterwards.
- mem_rvalid outside the *_WAIT states is ignored.

## Timing
- Reset values: every output is 0; state = IDLE; pending = 0. Reset taking effect mid-sequence aborts it with no PC change.
- stall = busy | (IDLE & accepted request), combinational, so stall is high in the accept cycle T. All other outputs are registered.
- CALL accepted at T: pushes at T+1..T+NW, DRAIN, JUMP at T+NW+STALL_CYCLES+1. stall is low from the following cycle unless a pending INT is accepted, in which case stall stays high continuously.
- INT adds one cycle (PUSHF). RET/RTI latency depends on mem_rvalid; minimum is 2 cycles per pop.
- uop_valid is high exactly in PUSH, PUSHF, POP and POPF cycles.

## Test plan
- CALL, ret_pc = 0x0001_2345, target = 0x100, at T → T+1: uop 0x6008/data 0x2345; T+2: 0x6009/0x0001; T+3..T+4: NOP with stall = 1; T+5: change_pc = 1, pc_out = 0x100; T+6: stall = 0.
- RET, mem_rvalid delayed 3 cycles per pop, data 0x0001 then 0x2345 → uops 0x7009, 0x7008, one per valid; pc_out = 0x0001_2345 with a single change_pc pulse.
- INT, flags_in = 3'b101, ret_pc = 0x0000_0042 → pushes 0x6008/0x0042, 0x6009/0x0000, 0x600A/0x0005; JUMP pc_out = 0x20.
- RTI, pop data 0x0005, 0x0000, 0x0042 → uops 0x700A, 0x7009, 0x7008; change_pc and restore_flags in the same cycle; pc_out = 0x42, flags_out = 3'b101.
- intr pulsed during a CALL DRAIN → CALL completes; the INT is accepted the next cycle; stall never drops; ret_pc for the INT is latched at that accept.
- call+ret in the same cycle → CALL taken, RET dropped.
- reset low during RET POP_WAIT → all outputs 0 asynchronously; a later mem_rvalid is ignored; no change_pc.
